uart_cmd_parser: RTL



---
 rtl/uart_cmd_parser_if.sv | 32 +++
 rtl/uart_cmd_parser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - received-byte input and register-bus request bundle for uart_cmd_parser
interface uart_cmd_parser_if;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic        err_o;

    // The parser consumes bytes and produces requests.
    modport slave (
        input  data_i,
        input  valid_i,
        output addr_o,
        output data_o,
        output rw_o,
        output valid_o,
        output err_o
    );

    // The byte source and request sink.
    modport master (
        output data_i,
        output valid_i,
        input  addr_o,
        input  data_o,
        input  rw_o,
        input  valid_o,
        input  err_o
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII R/W command line parser producing single-cycle register-bus requests
// Optional inter-byte timeout compiled in with `define UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter int TIMEOUT_CLOCKS = 100000
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_parser_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_EOL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_buf_q, addr_buf_d;
    logic [15:0] data_buf_q, data_buf_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_o_q, addr_o_d;
    logic [15:0] data_o_q, data_o_d;
    logic        rw_o_q, rw_o_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        fault;
    logic        is_term;
    logic [4:0]  hex;

    // Returns {is_hex, nibble}.
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        logic [7:0] t;
        t = 8'h00;
        if (b >= 8'h30 && b <= 8'h39) begin
            t = b - 8'h30;
            return {1'b1, t[3:0]};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            t = b - 8'h37;
            return {1'b1, t[3:0]};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            t = b - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'd0;
    endfunction

    assign hex     = hex_dec(bus.data_i);
    assign is_term = (bus.data_i == 8'h0D) || (bus.data_i == 8'h0A);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CLOCKS + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_buf_d = addr_buf_q;
        data_buf_d = data_buf_q;
        cnt_d      = cnt_q;
        addr_o_d   = addr_o_q;
        data_o_d   = data_o_q;
        rw_o_d     = rw_o_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        fault      = 1'b0;

        if (bus.valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.data_i == 8'h52) begin
                        state_d = ST_ADDR;
                        rw_d    = 1'b0;
                    end else if (bus.data_i == 8'h57) begin
                        state_d = ST_ADDR;
                        rw_d    = 1'b1;
                    end else if (!is_term) begin
                        fault = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (hex[4]) begin
                        addr_buf_d = {addr_buf_q[11:0], hex[3:0]};
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = rw_q ? ST_DATA : ST_EOL;
                        end
                    end else begin
                        fault = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (hex[4]) begin
                        data_buf_d = {data_buf_q[11:0], hex[3:0]};
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = ST_EOL;
                        end
                    end else begin
                        fault = 1'b1;
                    end
                end
                ST_EOL: begin
                    if (is_term) begin
                        addr_o_d   = addr_buf_q;
                        data_o_d   = rw_q ? data_buf_q : 16'h0000;
                        rw_o_d     = rw_q;
                        valid_d    = 1'b1;
                        state_d    = ST_IDLE;
                        rw_d       = 1'b0;
                        addr_buf_d = 16'h0000;
                        data_buf_d = 16'h0000;
                        cnt_d      = 2'd0;
                    end else begin
                        fault = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
        // A byte arriving on the expiry cycle wins over the timeout.
        if (bus.valid_i || state_q == ST_IDLE) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CLOCKS)) begin
            tmr_d = '0;
            fault = 1'b1;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
`endif

        // Abandon the partial line; published outputs are left untouched.
        if (fault) begin
            err_d      = 1'b1;
            state_d    = ST_IDLE;
            rw_d       = 1'b0;
            addr_buf_d = 16'h0000;
            data_buf_d = 16'h0000;
            cnt_d      = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_buf_q <= 16'h0000;
            data_buf_q <= 16'h0000;
            cnt_q      <= 2'd0;
            addr_o_q   <= 16'h0000;
            data_o_q   <= 16'h0000;
            rw_o_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
            tmr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_buf_q <= addr_buf_d;
            data_buf_q <= data_buf_d;
            cnt_q      <= cnt_d;
            addr_o_q   <= addr_o_d;
            data_o_q   <= data_o_d;
            rw_o_q     <= rw_o_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
            tmr_q      <= tmr_d;
`endif
        end
    end

    assign bus.addr_o  = addr_o_q;
    assign bus.data_o  = data_o_q;
    assign bus.rw_o    = rw_o_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;

endmodule
